// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//
// Front end of the processor. It presents the program counter straight to a
// synchronous instruction memory, pairs each returned word with the address
// it came from, and decides which returned words may be executed.
//
// A program begins with a one-cycle PRIME bubble that covers the memory
// latency. In RUN, one instruction is delivered per cycle. A taken branch
// discards the wrong-path word that is already in flight. Delivering
// HALT_CODE stops the program.
//
// Parameters
//   A          program address width (matches the program counter)
//   W          instruction width
//   HALT_CODE  instruction encoding that ends a program
//
// Ports
//   clk           single clock, rising edge
//   Reset         synchronous, active-high reset
//   Start         one-cycle pulse: begin or restart a program
//   ProgCtr       current program counter value
//   branch_taken  a branch or jump is being applied to the program counter
//   imem_addr     instruction memory read address (equal to ProgCtr)
//   imem_data     memory read data, valid one cycle after its address
//   Instr         fetched instruction (follows imem_data)
//   InstrPC       address that Instr was fetched from
//   instr_valid   Instr is live and may be executed
//   Done          the program has halted
//   fetch_count   valid instructions delivered since the last Start
// ---------------------------------------------------------------------------
module instr_fetch #(
    parameter int            A         = 10,
    parameter int            W         = 9,
    parameter logic [W-1:0]  HALT_CODE = '1
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [A-1:0]  ProgCtr,
    input  logic          branch_taken,
    output logic [A-1:0]  imem_addr,
    input  logic [W-1:0]  imem_data,
    output logic [W-1:0]  Instr,
    output logic [A-1:0]  InstrPC,
    output logic          instr_valid,
    output logic          Done,
    output logic [15:0]   fetch_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

    state_t         state;
    state_t         state_next;
    logic           squash;       // current RUN cycle holds a wrong-path word
    logic           squash_next;
    logic           valid;
    logic           done;
    logic [A-1:0]   instr_pc;
    logic [15:0]    count;

    // The memory is addressed directly by the program counter. The word that
    // comes back one cycle later is therefore paired with the PC registered
    // once.
    assign imem_addr = ProgCtr;

    // NOTE: Instr is pure wiring from the memory read port. It carries no
    // flop and no reset value; instr_valid qualifies it.
    assign Instr = imem_data;

    assign InstrPC     = instr_pc;
    assign instr_valid = valid;
    assign Done        = done;
    assign fetch_count = count;

    // -----------------------------------------------------------------------
    // Next state and outputs
    // -----------------------------------------------------------------------
    // NOTE: every signal written here gets a default first. Then no path
    // through the case statement leaves a value unassigned, so no latch can
    // be inferred.
    always_comb begin
        state_next  = state;
        squash_next = 1'b0;
        valid       = 1'b0;
        done        = 1'b0;

        unique case (state)
            IDLE: begin
                state_next = IDLE;
            end

            PRIME: begin
                // Memory data is stale for this one cycle.
                state_next = RUN;
            end

            RUN: begin
                valid = !squash;
                if (valid && (imem_data == HALT_CODE)) begin
                    // Halt wins over a simultaneous branch. The halt word
                    // itself is still counted as delivered.
                    state_next = HALT;
                end else if (valid && branch_taken) begin
                    // The word fetched during this cycle is on the wrong path.
                    // A branch raised during a squash cycle is not
                    // qualified by valid, so it is ignored here.
                    squash_next = 1'b1;
                end
            end

            HALT: begin
                done = 1'b1;
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // A restart overrides halt and squash from any state.
        if (Start) begin
            state_next  = PRIME;
            squash_next = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. Then every
    // flop samples the values from before the edge, whatever order the
    // statements are written in.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state    <= IDLE;
            squash   <= 1'b0;
            instr_pc <= '0;
            count    <= '0;
        end else begin
            state    <= state_next;
            squash   <= squash_next;
            instr_pc <= ProgCtr;

            if (Start) begin
                count <= '0;
            end else if (valid && (count != COUNT_MAX)) begin
                // Saturate instead of wrapping.
                count <= count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
//
// Bench for instr_fetch. It contains:
//   - a synchronous instruction memory (one-cycle read latency);
//   - a program counter that restarts on Start and follows accepted branches;
//   - a reference model of the fetch stage at program level. The model tracks
//     "running", "halted" and "invalid cycles still owed", and from these it
//     computes the expected output values.
//
// All stimulus is driven on the falling clock edge, and outputs are compared
// at the same point, away from the rising edge.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

    localparam int           A         = 10;
    localparam int           W         = 9;
    localparam logic [W-1:0] HALT_CODE = '1;
    localparam int           DEPTH     = 1 << A;

    logic          clk = 1'b0;
    logic          Reset = 1'b1;
    logic          Start = 1'b0;
    logic [A-1:0]  ProgCtr = '0;
    logic          branch_taken = 1'b0;
    logic [A-1:0]  imem_addr;
    logic [W-1:0]  imem_data;
    logic [W-1:0]  Instr;
    logic [A-1:0]  InstrPC;
    logic          instr_valid;
    logic          Done;
    logic [15:0]   fetch_count;

    instr_fetch #(
        .A         (A),
        .W         (W),
        .HALT_CODE (HALT_CODE)
    ) dut (
        .clk          (clk),
        .Reset        (Reset),
        .Start        (Start),
        .ProgCtr      (ProgCtr),
        .branch_taken (branch_taken),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .Instr        (Instr),
        .InstrPC      (InstrPC),
        .instr_valid  (instr_valid),
        .Done         (Done),
        .fetch_count  (fetch_count)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory.
    logic [W-1:0] mem [DEPTH];
    always @(posedge clk) imem_data <= mem[imem_addr];

    int tests  = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    bit           m_known  = 1'b0;  // model is meaningful once Reset has been seen
    bit           m_active = 1'b0;  // a program has been started
    bit           m_done   = 1'b0;  // the program has delivered its halt word
    int           m_owed   = 0;     // invalid cycles still owed (bubble or squash)
    int           m_cnt    = 0;     // instructions delivered since Start
    logic [A-1:0] m_ipc    = '0;    // address of the word now on Instr
    logic [A-1:0] m_pc     = '0;    // program counter for the current cycle

    function automatic bit exp_valid();
        return m_active && !m_done && (m_owed == 0);
    endfunction

    // One clock cycle: compare this cycle's outputs with the model, drive
    // this cycle's inputs, then advance the model and program counter across
    // the coming rising edge.
    task automatic cycle(input bit s, input bit r, input bit b, input logic [A-1:0] tgt);
        bit           v;
        logic [W-1:0] word;
        @(negedge clk);
        v    = exp_valid();
        word = mem[m_ipc];
        if (m_known) begin
            check("instr_valid", {31'd0, instr_valid}, {31'd0, v});
            check("done", {31'd0, Done}, {31'd0, m_done});
            check("fetch_count", {16'd0, fetch_count}, m_cnt);
            check("instr_pc", {22'd0, InstrPC}, {22'd0, m_ipc});
            if (v) check("instr", {23'd0, Instr}, {23'd0, word});
        end

        Start        = s;
        Reset        = r;
        branch_taken = b;
        ProgCtr      = m_pc;
        #1;
        check("imem_addr", {22'd0, imem_addr}, {22'd0, m_pc});

        if (r) begin
            m_known  = 1'b1;
            m_active = 1'b0;
            m_done   = 1'b0;
            m_owed   = 0;
            m_cnt    = 0;
            m_ipc    = '0;
        end else begin
            m_ipc = m_pc;
            if (s) begin
                m_active = 1'b1;
                m_done   = 1'b0;
                m_owed   = 1;
                m_cnt    = 0;
            end else if (v) begin
                if (m_cnt < 65535) m_cnt++;
                if (word == HALT_CODE) m_done = 1'b1;
                else if (b)            m_owed = 1;
            end else if (m_owed > 0) begin
                m_owed--;
            end
        end

        // A branch is accepted only from a live, non-halting instruction.
        if (r || s)                              m_pc = '0;
        else if (v && b && (word != HALT_CODE))  m_pc = tgt;
        else                                     m_pc = m_pc + 1'b1;
    endtask

    task automatic fill_no_halt();
        for (int i = 0; i < DEPTH; i++) mem[i] = W'($urandom_range(0, 510));
    endtask

    initial begin
        bit held;
        fill_no_halt();

        // Reset state
        cycle(0, 1, 0, '0);
        cycle(0, 1, 0, '0);
        cycle(0, 0, 0, '0);

        // Straight-line program ending in a halt at address 5
        for (int i = 0; i < 5; i++) mem[i] = W'(i + 1);
        mem[5] = HALT_CODE;
        cycle(1, 0, 0, '0);
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, '0);
        check("prog_done", {31'd0, Done}, 32'd1);
        check("prog_count", {16'd0, fetch_count}, 32'd6);

        // Taken branch while InstrPC == 2, target 20
        cycle(0, 1, 0, '0);
        fill_no_halt();
        mem[25] = HALT_CODE;
        cycle(1, 0, 0, '0);
        for (int i = 0; i < 14; i++) cycle(0, 0, exp_valid() && (m_ipc == 2), A'(20));
        check("branch_count", {16'd0, fetch_count}, 32'd9);

        // Branch held two cycles from InstrPC == 3, target 30
        cycle(0, 1, 0, '0);
        fill_no_halt();
        mem[32] = HALT_CODE;
        cycle(1, 0, 0, '0);
        held = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (held) begin
                cycle(0, 0, 1, A'(30));
                held = 1'b0;
            end else if (exp_valid() && (m_ipc == 3)) begin
                cycle(0, 0, 1, A'(30));
                held = 1'b1;
            end else begin
                cycle(0, 0, 0, A'(30));
            end
        end
        check("hold_count", {16'd0, fetch_count}, 32'd7);

        // Restart during RUN once three instructions have been delivered
        cycle(0, 1, 0, '0);
        fill_no_halt();
        cycle(1, 0, 0, '0);
        for (int i = 0; i < 20 && m_cnt != 3; i++) cycle(0, 0, 0, '0);
        check("restart_reach3", m_cnt, 32'd3);
        cycle(1, 0, 0, '0);
        cycle(0, 0, 0, '0);
        check("restart_count", {16'd0, fetch_count}, 32'd0);
        check("restart_bubble", {31'd0, instr_valid}, 32'd0);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, '0);
        check("restart_resume", {16'd0, fetch_count}, 32'd5);

        // Reset together with Start; then Reset while halted
        cycle(1, 1, 0, '0);
        cycle(0, 0, 0, '0);
        check("rst_start_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_start_done", {31'd0, Done}, 32'd0);
        mem[0] = HALT_CODE;
        cycle(1, 0, 0, '0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, '0);
        check("halt_done", {31'd0, Done}, 32'd1);
        check("halt_count", {16'd0, fetch_count}, 32'd1);
        cycle(0, 1, 0, '0);
        cycle(0, 0, 0, '0);
        check("halt_rst_done", {31'd0, Done}, 32'd0);
        check("halt_rst_count", {16'd0, fetch_count}, 32'd0);

        // Random programs, branches, restarts and resets
        for (int i = 0; i < DEPTH; i++)
            mem[i] = ($urandom_range(0, 39) == 0) ? HALT_CODE : W'($urandom_range(0, 510));
        cycle(1, 0, 0, '0);
        for (int i = 0; i < 4000; i++)
            cycle($urandom_range(0, 63) == 0, $urandom_range(0, 199) == 0,
                  $urandom_range(0, 5) == 0, A'($urandom_range(0, DEPTH - 1)));

        // Long non-halting program: the count must stick at FFFF
        cycle(0, 1, 0, '0);
        fill_no_halt();
        cycle(1, 0, 0, '0);
        for (int i = 0; i < 65545; i++) cycle(0, 0, 0, '0);
        check("sat_count", {16'd0, fetch_count}, 32'h0000_FFFF);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, '0);
        check("sat_hold", {16'd0, fetch_count}, 32'h0000_FFFF);

        // Reset in the middle of RUN
        cycle(0, 1, 0, '0);
        cycle(0, 0, 0, '0);
        check("midrun_valid", {31'd0, instr_valid}, 32'd0);
        check("midrun_count", {16'd0, fetch_count}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
